// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) digit-serial multiplier slice:
// default geometry, feeder state encoding and the NIST B-163 polynomial.
package gf2m_pkg;

  // Digit width seen by the multiplier core and the field size m.
  localparam int DIGITAL    = 32;
  localparam int DATA_WIDTH = 163;

  // Number of digits needed to cover m bits, rounding up.
  function automatic int digits_for(input int width, input int digit);
    return (width + digit - 1) / digit;
  endfunction

  localparam int NUM_DIGITS = digits_for(DATA_WIDTH, DIGITAL);
  localparam int PAD_WIDTH  = NUM_DIGITS * DIGITAL;

  // Feeder sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } feeder_state_e;

  // Low terms of x^163 + x^7 + x^6 + x^3 + 1 (the x^m term is implicit).
  localparam logic [162:0] GF_POLY_163 = 163'hC9;

endpackage

// File: rtl/gf2m_digit_shifter.sv
// Operand-b serialiser: loads a zero-extended operand and shifts it left by
// one digit per enable, exposing the most-significant digit.
module gf2m_digit_shifter #(
  parameter int DIGITAL    = gf2m_pkg::DIGITAL,
  parameter int DATA_WIDTH = gf2m_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  shift_en,
  output logic [DIGITAL-1:0]    digit
);
  import gf2m_pkg::*;

  localparam int NUM_DIGITS = digits_for(DATA_WIDTH, DIGITAL);
  localparam int PAD_WIDTH  = NUM_DIGITS * DIGITAL;

  logic [PAD_WIDTH-1:0] padded;
  logic [PAD_WIDTH-1:0] shreg_reg;
  logic [PAD_WIDTH-1:0] shreg_next;

  // Zero-extend only when m is not a whole number of digits.
  generate
    if (PAD_WIDTH > DATA_WIDTH) begin : g_pad
      assign padded = {{(PAD_WIDTH - DATA_WIDTH){1'b0}}, load_data};
    end else begin : g_nopad
      assign padded = load_data;
    end
  endgenerate

  // Each digit lane either loads, takes the lane below it, or holds.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
      if (gi == 0) begin : g_bottom
        assign shreg_next[DIGITAL-1:0] =
          load     ? padded[DIGITAL-1:0] :
          shift_en ? {DIGITAL{1'b0}}     :
                     shreg_reg[DIGITAL-1:0];
      end else begin : g_upper
        assign shreg_next[gi*DIGITAL +: DIGITAL] =
          load     ? padded[gi*DIGITAL +: DIGITAL]        :
          shift_en ? shreg_reg[(gi-1)*DIGITAL +: DIGITAL] :
                     shreg_reg[gi*DIGITAL +: DIGITAL];
      end
    end
  endgenerate

  // Shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_reg <= '0;
    end else begin
      shreg_reg <= shreg_next;
    end
  end

  assign digit = shreg_reg[PAD_WIDTH-1 -: DIGITAL];

endmodule

// File: rtl/gf2m_digit_feeder.sv
// Initiator-side sequencer for the digit-serial gf2m core: accepts one operand
// set, pulses start, streams b MSD-first, captures the result on done and
// offers it downstream, with a watchdog for a core that never finishes.
module gf2m_digit_feeder #(
  parameter int DIGITAL    = gf2m_pkg::DIGITAL,
  parameter int DATA_WIDTH = gf2m_pkg::DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [DATA_WIDTH-1:0] in_g,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_t,
  output logic                  out_err,
  output logic                  mul_start,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_g,
  output logic [DIGITAL-1:0]    mul_b,
  input  logic [DATA_WIDTH-1:0] mul_t,
  input  logic                  mul_done
);
  import gf2m_pkg::*;

  localparam int NUM_DIGITS = digits_for(DATA_WIDTH, DIGITAL);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  feeder_state_e state_reg, state_next;

  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [TMO_W-1:0]      tmo_reg, tmo_next;
  logic                  in_ready_reg, in_ready_next;
  logic                  out_valid_reg, out_valid_next;
  logic                  out_err_reg, out_err_next;
  logic [DATA_WIDTH-1:0] out_t_reg, out_t_next;
  logic                  mul_start_reg, mul_start_next;
  logic [DATA_WIDTH-1:0] mul_a_reg, mul_a_next;
  logic [DATA_WIDTH-1:0] mul_g_reg, mul_g_next;
  logic [DIGITAL-1:0]    mul_b_reg, mul_b_next;

  logic                  shf_load;
  logic                  shf_shift;
  logic [DIGITAL-1:0]    shf_digit;

  gf2m_digit_shifter #(
    .DIGITAL    (DIGITAL),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (shf_load),
    .load_data (in_b),
    .shift_en  (shf_shift),
    .digit     (shf_digit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; the FEED phase runs a fixed NUM_DIGITS cycles with no stalls.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_valid) state_next = ST_START;
      ST_START: state_next = ST_FEED;
      ST_FEED:  if (idx_reg == LAST_IDX) state_next = ST_WAIT;
      ST_WAIT:  if (mul_done || (tmo_reg == TMO_LAST)) state_next = ST_HOLD;
      ST_HOLD:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath; handshake flags
  // follow the state being entered so they are valid from its first cycle.
  always_comb begin
    shf_load       = 1'b0;
    shf_shift      = 1'b0;
    idx_next       = idx_reg;
    tmo_next       = tmo_reg;
    mul_a_next     = mul_a_reg;
    mul_g_next     = mul_g_reg;
    mul_b_next     = '0;
    out_t_next     = out_t_reg;
    out_err_next   = out_err_reg;
    in_ready_next  = (state_next == ST_IDLE);
    out_valid_next = (state_next == ST_HOLD);
    mul_start_next = (state_next == ST_START);
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          mul_a_next = in_a;
          mul_g_next = in_g;
          shf_load   = 1'b1;
        end
      end
      ST_START: begin
        // Digit 0 goes out on the cycle after the start pulse.
        idx_next   = '0;
        tmo_next   = '0;
        mul_b_next = shf_digit;
        shf_shift  = 1'b1;
      end
      ST_FEED: begin
        if (idx_reg != LAST_IDX) begin
          idx_next   = idx_reg + 1'b1;
          mul_b_next = shf_digit;
          shf_shift  = 1'b1;
        end
      end
      ST_WAIT: begin
        // The core clears t the cycle after done, so capture on the pulse itself.
        if (mul_done) begin
          out_t_next   = mul_t;
          out_err_next = 1'b0;
        end else if (tmo_reg == TMO_LAST) begin
          out_t_next   = '0;
          out_err_next = 1'b1;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg       <= '0;
      tmo_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_err_reg   <= 1'b0;
      out_t_reg     <= '0;
      mul_start_reg <= 1'b0;
      mul_a_reg     <= '0;
      mul_g_reg     <= '0;
      mul_b_reg     <= '0;
    end else begin
      idx_reg       <= idx_next;
      tmo_reg       <= tmo_next;
      in_ready_reg  <= in_ready_next;
      out_valid_reg <= out_valid_next;
      out_err_reg   <= out_err_next;
      out_t_reg     <= out_t_next;
      mul_start_reg <= mul_start_next;
      mul_a_reg     <= mul_a_next;
      mul_g_reg     <= mul_g_next;
      mul_b_reg     <= mul_b_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_err   = out_err_reg;
  assign out_t     = out_t_reg;
  assign mul_start = mul_start_reg;
  assign mul_a     = mul_a_reg;
  assign mul_g     = mul_g_reg;
  assign mul_b     = mul_b_reg;

endmodule

// File: tb/tb_gf2m_digit_feeder.sv
// Bench for gf2m_digit_feeder: a behavioural gf2m core model rebuilds b from
// the streamed digits and answers with a*b mod g; expectations come from a
// plain polynomial multiply-and-reduce of the operands as presented.
`timescale 1ns/1ps
module tb_gf2m_digit_feeder;
  import gf2m_pkg::*;

  localparam int W   = DATA_WIDTH;
  localparam int D   = DIGITAL;
  localparam int N   = NUM_DIGITS;
  localparam int P   = PAD_WIDTH;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid, in_ready, out_valid, out_ready, out_err;
  logic [W-1:0] in_a, in_b, in_g, out_t, mul_a, mul_g, mul_t;
  logic [D-1:0] mul_b;
  logic         mul_start, mul_done;

  int n_assert = 0;
  int n_fail   = 0;

  gf2m_digit_feeder #(.DIGITAL(D), .DATA_WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_g(in_g),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_t(out_t), .out_err(out_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_g(mul_g), .mul_b(mul_b),
    .mul_t(mul_t), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // a*b mod (x^m + g) by schoolbook carry-less multiply then top-down reduction.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] g);
    logic [2*W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) p = p ^ ({{W{1'b0}}, a} << i);
    for (int i = 2*W-2; i >= W; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p = p ^ ({{W{1'b0}}, g} << (i - W));
      end
    return p[W-1:0];
  endfunction

  // Digit k of b, counting from the most-significant end of the padded value.
  function automatic logic [D-1:0] exp_digit(input logic [W-1:0] b, input int k);
    logic [P-1:0] s;
    s = P'(b) >> (P - D*(k+1));
    return s[D-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // Core model: rebuild b from the digit stream, answer done right after the last digit.
  logic         stub_active;
  int           stub_cnt;
  logic [P-1:0] stub_b, stub_full;
  logic         stub_nodone = 1'b0;
  logic         stub_spur   = 1'b0;
  assign stub_full = {stub_b[P-D-1:0], mul_b};

  // Core model sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_active <= 1'b0;
      stub_cnt    <= 0;
      stub_b      <= '0;
      mul_done    <= 1'b0;
      mul_t       <= '0;
    end else begin
      mul_done <= 1'b0;
      mul_t    <= '0;
      if (mul_start) begin
        stub_active <= 1'b1;
        stub_cnt    <= 0;
        stub_b      <= '0;
      end else if (stub_active) begin
        stub_b   <= stub_full;
        stub_cnt <= stub_cnt + 1;
        if (stub_spur && stub_cnt == 2) begin
          mul_done <= 1'b1;
          mul_t    <= {W{1'b1}};
        end
        if (stub_cnt == N-1) begin
          stub_active <= 1'b0;
          if (!stub_nodone) begin
            mul_done <= 1'b1;
            mul_t    <= gf_mul(mul_a, stub_full[W-1:0], mul_g);
          end
        end
      end
    end
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkd(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check1({name, ":ready"}, in_ready, 1'b1);
  endtask

  // One full transaction: accept, digit stream, result, optional backpressure.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                        input logic exp_err, input int hold_cyc, input string name);
    logic [W-1:0] exp_t;
    int lat, exp_lat;
    exp_t   = exp_err ? '0 : gf_mul(a, b, g);
    exp_lat = exp_err ? (N + 2 + TMO) : (N + 3);
    wait_ready(name);
    in_a = a; in_b = b; in_g = g; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check1({name, ":start"}, mul_start, 1'b1);
    check1({name, ":busy"}, in_ready, 1'b0);
    checkw({name, ":mul_a"}, mul_a, a);
    checkw({name, ":mul_g"}, mul_g, g);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) check1({name, ":start_once"}, mul_start, 1'b0);
      if (lat >= 2 && lat <= N + 1)
        checkd($sformatf("%s:digit%0d", name, lat - 2), mul_b, exp_digit(b, lat - 2));
    end
    checki({name, ":latency"}, lat, exp_lat);
    check1({name, ":out_valid"}, out_valid, 1'b1);
    checkw({name, ":out_t"}, out_t, exp_t);
    check1({name, ":out_err"}, out_err, exp_err);
    checkd({name, ":mul_b_idle"}, mul_b, '0);
    $display("op %s: a=%0h b=%0h t=%0h err=%0b lat=%0d", name, a, b, out_t, out_err, lat);
    if (hold_cyc > 0) begin
      in_a = ~a; in_b = ~b; in_valid = 1'b1;
    end
    out_ready = 1'b0;
    for (int i = 0; i < hold_cyc; i++) begin
      @(posedge clk); #1;
      check1($sformatf("%s:hold%0d_valid", name, i), out_valid, 1'b1);
      checkw($sformatf("%s:hold%0d_t", name, i), out_t, exp_t);
      check1($sformatf("%s:hold%0d_ready", name, i), in_ready, 1'b0);
      check1($sformatf("%s:hold%0d_nostart", name, i), mul_start, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check1({name, ":released"}, out_valid, 1'b0);
    check1({name, ":ready_back"}, in_ready, 1'b1);
    check1({name, ":no_early_accept"}, mul_start, 1'b0);
    checkw({name, ":mul_a_held"}, mul_a, a);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_g = '0;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check1("rst:in_ready", in_ready, 1'b1);
    check1("rst:out_valid", out_valid, 1'b0);
    check1("rst:out_err", out_err, 1'b0);
    checkw("rst:out_t", out_t, '0);
    check1("rst:mul_start", mul_start, 1'b0);
    checkw("rst:mul_a", mul_a, '0);
    checkw("rst:mul_g", mul_g, '0);
    checkd("rst:mul_b", mul_b, '0);
    rst = 1'b0;

    // Unit operands: only the last digit of b is non-zero.
    run_op(W'(1), W'(1), GF_POLY_163, 1'b0, 0, "one");
    checkw("one:t_is_1", out_t, W'(1));

    // x^162 * x = x^163, which reduces to g; also exercises backpressure.
    ra = W'(1) << 162;
    run_op(ra, W'(2), GF_POLY_163, 1'b0, 3, "x163");
    checkw("x163:t_is_c9", out_t, W'('hC9));

    // Top bit of b lands in bit 2 of digit 0.
    rb = W'(1) << 162;
    run_op(rand_w(), rb, GF_POLY_163, 1'b0, 1, "bmsb");

    // Done pulse during FEED must be ignored.
    stub_spur = 1'b1;
    run_op(rand_w(), rand_w(), GF_POLY_163, 1'b0, 0, "spur");
    stub_spur = 1'b0;

    // Core that never answers.
    stub_nodone = 1'b1;
    run_op(rand_w(), rand_w(), GF_POLY_163, 1'b1, 1, "tmo");
    stub_nodone = 1'b0;

    // Reset while digit 3 is on mul_b.
    wait_ready("rstmid");
    ra = rand_w(); rb = rand_w();
    in_a = ra; in_b = rb; in_g = GF_POLY_163; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkd("rstmid:digit3", mul_b, exp_digit(rb, 3));
    #2 rst = 1'b1;
    #1;
    check1("rstmid:in_ready", in_ready, 1'b1);
    check1("rstmid:out_valid", out_valid, 1'b0);
    check1("rstmid:out_err", out_err, 1'b0);
    checkw("rstmid:out_t", out_t, '0);
    check1("rstmid:mul_start", mul_start, 1'b0);
    checkw("rstmid:mul_a", mul_a, '0);
    checkw("rstmid:mul_g", mul_g, '0);
    checkd("rstmid:mul_b", mul_b, '0);
    $display("op rstmid: reset applied during digit 3");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check1("rstmid:no_result", out_valid, 1'b0);
    run_op(W'(3), W'(3), GF_POLY_163, 1'b0, 0, "rst_recover");
    checkw("rst_recover:t_is_5", out_t, W'(5));

    // Random operands and random field polynomial low terms.
    for (int i = 0; i < 4; i++) begin
      run_op(rand_w(), rand_w(), (i[0] ? rand_w() : GF_POLY_163), 1'b0,
             int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gf2m_digit_feeder.md
Name: gf2m_digit_feeder

Overview:
- Initiator-side sequencer for the digit-serial GF(2^m) multiplier core `gf2m`.
- Accepts one full-width operand set (a, b, g) on a valid/ready input, then pulses `mul_start`.
- Streams b to the core one DIGITAL-bit digit per cycle, most-significant digit first, and captures the core's result on its one-cycle `done` pulse.
- Presents the result on a valid/ready output, with a watchdog for a core that never signals done.

Parameters:
- DIGITAL, 32: digit width in bits; must equal the core's DIGITAL.
- DATA_WIDTH, 163: field size m; operand and result width.
- TIMEOUT, 16: maximum WAIT cycles before the error exit.
- NUM_DIGITS (localparam) = (DATA_WIDTH+DIGITAL-1)/DIGITAL. Default is 6, which matches the core's ITERATION_NUMBER+1 CAL cycles.
- PAD_WIDTH (localparam) = NUM_DIGITS*DIGITAL. Default is 192.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  feeder can accept operands
- in_a  in  DATA_WIDTH  multiplicand
- in_b  in  DATA_WIDTH  multiplier (serialised)
- in_g  in  DATA_WIDTH  reduction polynomial, low terms (x^m implicit)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_t  out  DATA_WIDTH  product a*b mod g
- out_err  out  1  qualifies out_valid; timeout occurred
- mul_start  out  1  start pulse to core
- mul_a  out  DATA_WIDTH  held a to core
- mul_g  out  DATA_WIDTH  held g to core
- mul_b  out  DIGITAL  current digit to core
- mul_t  in  DATA_WIDTH  core t_i_j
- mul_done  in  1  core done pulse

Behaviour:
- Reset (async, any state) sets all of the following:
  - state=IDLE, in_ready=1.
  - out_valid=0, out_err=0, out_t=0, mul_start=0.
  - mul_a=0, mul_g=0, mul_b=0, digit index=0, timeout counter=0.
  - All outputs are registered.
  - Reset mid-operation abandons the operation. No result is emitted; the core is reset by the same system reset.
- States: IDLE, START, FEED, WAIT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a→mul_a, in_g→mul_g, and zero-extend in_b to PAD_WIDTH in the shift register. Go to START.
- START:
  - in_ready=0, mul_start=1 for exactly this cycle. Next state FEED, index=0.
- FEED:
  - mul_b = padded bits [PAD_WIDTH-1-DIGITAL*idx -: DIGITAL]; digit 0 appears the cycle after mul_start.
  - Index increments every cycle, with no stalls.
  - When idx==NUM_DIGITS-1, the next state is WAIT.
  - The last digit coincides with the core's counter==ITERATION_NUMBER cycle.
- WAIT:
  - mul_b=0; the timeout counter increments each cycle.
  - On mul_done: out_t<=mul_t (captured in the same cycle, because the core clears t_i_j the next cycle), out_err<=0, go to HOLD.
  - With nominal core timing, mul_done is seen in the first WAIT cycle.
  - If the counter reaches TIMEOUT with no done: out_t<=0, out_err<=1, go to HOLD.
- HOLD:
  - out_valid=1; out_t and out_err stable.
  - On out_ready: out_valid<=0, return to IDLE; in_ready rises the next cycle.
- Latency, in_valid accept edge to out_valid high: NUM_DIGITS+3 cycles (9 by default).
- mul_done seen outside WAIT is ignored.
- mul_a and mul_g hold stable from the latch until the next accept.
- Throughput: one operation per NUM_DIGITS+4 cycles, with no overlap.
- When DATA_WIDTH is a multiple of DIGITAL, PAD_WIDTH equals DATA_WIDTH and no zero digit is inserted.

Decomposition:
- Shared package gf2m_pkg holds:
  - DIGITAL, DATA_WIDTH, NUM_DIGITS, PAD_WIDTH.
  - State encoding localparams.
  - GF_POLY_163 = 163'hC9 (x^163+x^7+x^6+x^3+1).
- One sub-module, gf2m_digit_shifter:
  - Load with zero-extend.
  - Left shift by DIGITAL per enable.
  - Top digit as output.

Test Plan:
- g=GF_POLY_163, a=1, b=1, with the real gf2m core attached → mul_b=0 for digits 0–4 and 0x1 on digit 5. out_t=1, out_err=0, out_valid 9 cycles after accept.
- a=2^162, b=2 → out_t=0xC9 (x^163 reduced).
- b=2^162 → digit 0 on mul_b = 0x00000004, digits 1–5 = 0. mul_start high exactly one cycle, the cycle before digit 0.
- out_ready held low 3 cycles → out_valid and out_t stable, in_ready=0, and a second in_valid is not accepted until the cycle after the out_ready handshake.
- Core replaced by a stub with mul_done tied 0 → after TIMEOUT=16 WAIT cycles: out_valid=1, out_err=1, out_t=0.
- rst asserted during FEED digit 3 → all outputs take reset values immediately. The next operation with a=3, b=3 gives out_t=5.
